muldiv_unit: RTL

Iterative multiply/divide unit in the execute stage, beside the ALU. It takes the same two 32-bit register operands, computes MULT/MULTU/DIV/DIVU over multiple cycles, and holds the result in the architectural HI/LO registers. Hazard logic uses `busy` to stall the pipeline. The HI/LO outputs feed the writeback mux for MFHI/MFLO.

---
 rtl/muldiv_unit.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// ============================================================================
// muldiv_unit : iterative MULT/MULTU/DIV/DIVU engine owning the HI/LO registers
// Optional divide datapath enabled by `define MULDIV_DIV_EN
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_unit (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [5:0] C_LAST_ITER = 6'd31;

  state_t      r_state;
  state_t      w_next;
  logic [5:0]  r_cnt;
  logic        r_sign_a;
  logic        r_sign_b;
  logic [31:0] r_mcand;
  logic [63:0] r_acc;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_idle_like;
  logic        w_signed_op;
  logic        w_start_run;
  logic        w_start_skip;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [32:0] w_mul_sum;
  logic [63:0] w_prod;

  assign w_idle_like = (r_state == IDLE) || (r_state == DONE);
  assign w_signed_op = ~op[0];
  assign w_abs_a     = (w_signed_op && A[31]) ? -A : A;
  assign w_abs_b     = (w_signed_op && B[31]) ? -B : B;

`ifdef MULDIV_DIV_EN
  logic        r_is_div;
  logic        r_bzero;
  logic [31:0] r_a_raw;
  logic [31:0] r_rem;
  logic [32:0] w_div_shift;
  logic [32:0] w_div_trial;
  logic [31:0] w_quo;
  logic [31:0] w_rem;

  assign w_start_run  = start;
  assign w_start_skip = 1'b0;

  // 33-bit partial remainder: previous remainder shifted with next dividend bit
  assign w_div_shift = {r_rem, r_acc[31]};
  assign w_div_trial = w_div_shift - {1'b0, r_mcand};
  assign w_quo       = (r_sign_a ^ r_sign_b) ? -r_acc[31:0] : r_acc[31:0];
  assign w_rem       = r_sign_a ? -r_rem : r_rem;
`else
  // Without a divider, divide requests complete immediately and leave HI/LO alone
  assign w_start_run  = start & ~op[1];
  assign w_start_skip = start &  op[1];
`endif

  // Multiplier bits live in r_acc[31:0] and are consumed LSB first
  assign w_mul_sum = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_mcand} : 33'd0);
  assign w_prod    = (r_sign_a ^ r_sign_b) ? -r_acc : r_acc;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_start_run)       w_next = RUN;
        else if (w_start_skip) w_next = DONE;
      end
      RUN: begin
        if (r_cnt == C_LAST_ITER) w_next = FIX;
      end
      FIX: begin
        w_next = DONE;
      end
      DONE: begin
        if (w_start_run)       w_next = RUN;
        else if (w_start_skip) w_next = DONE;
        else                   w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= IDLE;
      r_cnt    <= 6'd0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_mcand  <= 32'd0;
      r_acc    <= 64'd0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
`ifdef MULDIV_DIV_EN
      r_is_div <= 1'b0;
      r_bzero  <= 1'b0;
      r_a_raw  <= 32'd0;
      r_rem    <= 32'd0;
`endif
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE, DONE: begin
          if (w_start_run) begin
            r_cnt    <= 6'd0;
            r_sign_a <= w_signed_op & A[31];
            r_sign_b <= w_signed_op & B[31];
            r_mcand  <= w_abs_a;
            r_acc    <= {32'd0, w_abs_b};
`ifdef MULDIV_DIV_EN
            r_is_div <= op[1];
            r_bzero  <= (B == 32'd0);
            r_a_raw  <= A;
            r_rem    <= 32'd0;
            if (op[1]) begin
              r_mcand <= w_abs_b;
              r_acc   <= {32'd0, w_abs_a};
            end
`endif
          end else if (!start) begin
            if (hi_we) r_hi <= wdata;
            if (lo_we) r_lo <= wdata;
          end
        end
        RUN: begin
          r_cnt <= r_cnt + 6'd1;
`ifdef MULDIV_DIV_EN
          if (r_is_div) begin
            if (!w_div_trial[32]) begin
              r_rem        <= w_div_trial[31:0];
              r_acc[31:0]  <= {r_acc[30:0], 1'b1};
            end else begin
              r_rem        <= w_div_shift[31:0];
              r_acc[31:0]  <= {r_acc[30:0], 1'b0};
            end
          end else begin
            r_acc <= {w_mul_sum, r_acc[31:1]};
          end
`else
          r_acc <= {w_mul_sum, r_acc[31:1]};
`endif
        end
        FIX: begin
`ifdef MULDIV_DIV_EN
          if (r_is_div) begin
            if (r_bzero) begin
              r_hi <= r_a_raw;
              r_lo <= 32'hFFFF_FFFF;
            end else begin
              r_hi <= w_rem;
              r_lo <= w_quo;
            end
          end else begin
            r_hi <= w_prod[63:32];
            r_lo <= w_prod[31:0];
          end
`else
          r_hi <= w_prod[63:32];
          r_lo <= w_prod[31:0];
`endif
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state == RUN) || (r_state == FIX);
  assign done = (r_state == DONE);
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

`default_nettype wire
